// File: rtl/seq_mult32.sv
// -----------------------------------------------------------------------------
// seq_mult32 - multi-cycle 32x32 unsigned shift-and-add multiplier.
//
// One multiply takes 32 iterations of a 32-bit ripple-carry add. Each
// iteration adds the multiplicand (gated by the current multiplier LSB) to
// the running partial sum. The 33-bit result is then shifted right into the
// combined partial-sum / multiplier register.
//
// Ports:
//   clk_i      - single clock, rising edge
//   rst_i      - asynchronous active-high reset
//   start_i    - request a multiply (accepted in IDLE or DONE only)
//   a_i[31:0]  - multiplicand, captured on accept
//   b_i[31:0]  - multiplier, captured on accept
//   busy_o     - high while iterating (RUN)
//   done_o     - one-cycle pulse, product_o valid in this cycle
//   product_o  - last completed 64-bit product, held until next completion
// -----------------------------------------------------------------------------
module seq_mult32 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] product_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] m_q, m_d;
    logic [63:0] p_q, p_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] product_q, product_d;

    // Adder operands: partial sum plus multiplicand gated by the multiplier LSB.
    logic [31:0] add_a_s;
    logic [31:0] add_b_s;
    logic [31:0] add_sum_s;
    logic [32:0] add_carry_s;
    logic        add_cout_s;

    assign add_a_s = p_q[63:32];
    assign add_b_s = p_q[0] ? m_q : 32'h0000_0000;

    // Ripple-carry chain with the carry-in tied low.
    assign add_carry_s[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_ripple
            assign add_sum_s[gi]     = add_a_s[gi] ^ add_b_s[gi] ^ add_carry_s[gi];
            assign add_carry_s[gi+1] = (add_a_s[gi] & add_b_s[gi])
                                     | (add_carry_s[gi] & (add_a_s[gi] ^ add_b_s[gi]));
        end
    endgenerate
    assign add_cout_s = add_carry_s[32];

    // Next-state and datapath update logic.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    m_d     = a_i;
                    p_d     = {32'h0000_0000, b_i};
                    cnt_d   = 5'd0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // The carry-out is kept as bit 63, so the shift never loses a bit.
                p_d   = {add_cout_s, add_sum_s, p_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d   = S_DONE;
                    product_d = p_d;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    m_d     = a_i;
                    p_d     = {32'h0000_0000, b_i};
                    cnt_d   = 5'd0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            m_q       <= 32'h0000_0000;
            p_q       <= 64'h0000_0000_0000_0000;
            cnt_q     <= 5'd0;
            product_q <= 64'h0000_0000_0000_0000;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Status flags are decoded directly from state.
    assign busy_o    = (state_q == S_RUN);
    assign done_o    = (state_q == S_DONE);
    assign product_o = product_q;

endmodule

// File: tb/tb_seq_mult32.sv
module tb_seq_mult32;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] a_i     = 32'h0;
    logic [31:0] b_i     = 32'h0;
    logic        busy_o;
    logic        done_o;
    logic [63:0] product_o;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];

    seq_mult32 dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .product_o (product_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a start for exactly one accepting edge; caller is mid-cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        if (push) exp_q.push_back({32'h0, a} * {32'h0, b});
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Wait (bounded) for done, counting edges and busy cycles; check product.
    task automatic wait_done(input string tag, output int lat, output int busy_cnt);
        bit found;
        logic [63:0] exp;
        found    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (busy_o) busy_cnt++;
            @(posedge clk_i);
            #1;
            lat++;
            if (done_o) found = 1'b1;
        end
        tests++;
        assert (found) else begin
            fails++;
            $error("FAIL %s_timeout observed=no_done expected=done", tag);
        end
        if (found) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL %s_sb_empty observed=done expected=no_done", tag);
            end else begin
                exp = exp_q.pop_front();
                check64({tag, "_product"}, product_o, exp);
            end
        end
    endtask

    initial begin
        int lat;
        int bc;

        // Reset state.
        repeat (2) @(posedge clk_i);
        #1;
        check64("rst_busy", {63'h0, busy_o}, 64'h0);
        check64("rst_done", {63'h0, done_o}, 64'h0);
        check64("rst_product", product_o, 64'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Basic 3x5 with busy width, latency, single-cycle done and hold.
        issue(32'd3, 32'd5, 1'b1);
        check64("basic_busy_after_accept", {63'h0, busy_o}, 64'h1);
        wait_done("basic", lat, bc);
        check64("basic_latency", 64'(lat), 64'd32);
        check64("basic_busy_cycles", 64'(bc), 64'd32);
        check64("basic_busy_in_done", {63'h0, busy_o}, 64'h0);
        @(posedge clk_i);
        #1;
        check64("basic_done_one_cycle", {63'h0, done_o}, 64'h0);
        check64("basic_hold", product_o, 64'h0000_0000_0000_000F);

        // Max operands.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("max", lat, bc);
        check64("max_literal", product_o, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk_i);
        #1;

        // Zero multiplicand.
        issue(32'h0, 32'h1234_5678, 1'b1);
        wait_done("zero", lat, bc);
        @(posedge clk_i);
        #1;

        // Carry into the upper word.
        issue(32'h8000_0000, 32'd2, 1'b1);
        wait_done("carry", lat, bc);
        check64("carry_literal", product_o, 64'h0000_0001_0000_0000);
        @(posedge clk_i);
        #1;

        // Start during RUN is ignored.
        issue(32'd6, 32'd4, 1'b1);
        repeat (5) @(posedge clk_i);
        #1;
        issue(32'd7, 32'd9, 1'b0);
        check64("ignored_still_busy", {63'h0, busy_o}, 64'h1);
        wait_done("ignored", lat, bc);
        check64("ignored_latency", 64'(lat), 64'd26);
        check64("ignored_literal", product_o, 64'd24);

        // Back-to-back: start held in the DONE cycle.
        issue(32'd7, 32'd9, 1'b1);
        check64("b2b_busy_next", {63'h0, busy_o}, 64'h1);
        check64("b2b_done_dropped", {63'h0, done_o}, 64'h0);
        wait_done("b2b", lat, bc);
        check64("b2b_interval", 64'(lat + 1), 64'd33);
        check64("b2b_literal", product_o, 64'd63);
        @(posedge clk_i);
        #1;

        // Reset mid-run discards the multiply, asynchronously.
        issue(32'd10, 32'd10, 1'b0);
        repeat (15) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check64("midrst_busy", {63'h0, busy_o}, 64'h0);
        check64("midrst_done", {63'h0, done_o}, 64'h0);
        check64("midrst_product", product_o, 64'h0);
        // Reset wins over a simultaneous start.
        start_i = 1'b1;
        a_i     = 32'd10;
        b_i     = 32'd10;
        @(posedge clk_i);
        #1;
        check64("rst_vs_start_busy", {63'h0, busy_o}, 64'h0);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        // No done may appear for the discarded multiply.
        bc = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o) bc++;
        end
        check64("midrst_no_done", 64'(bc), 64'd0);
        check64("midrst_product_zero", product_o, 64'h0);

        // First multiply after reset.
        issue(32'd12, 32'd12, 1'b1);
        wait_done("after_rst", lat, bc);
        check64("after_rst_latency", 64'(lat), 64'd32);
        check64("after_rst_literal", product_o, 64'd144);

        check64("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
